adsr_envelope: RTL

Per-voice ADSR envelope generator producing the 16-bit amplitude word consumed by the oscillator's `env` input. A gate from the voice/key logic drives a five-state machine (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE). The machine ramps a 32-bit level accumulator at programmable per-stage rates, advancing once per sample tick. The envelope output is the top `D_WIDTH` bits of the accumulator.

---
 rtl/adsr_envelope.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/adsr_envelope.sv
// ============================================================================
// Module   : adsr_envelope
// Brief    : Per-voice ADSR envelope generator, tick-driven 5-state ramp.
//            Optional output velocity scaling under macro ADSR_VELOCITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adsr_envelope #(
   parameter int D_WIDTH = 16,
   parameter int R_WIDTH = 32
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               En,
   input  logic               gate,
   input  logic [R_WIDTH-1:0] attack_rate,
   input  logic [R_WIDTH-1:0] decay_rate,
   input  logic [D_WIDTH-1:0] sustain_level,
   input  logic [R_WIDTH-1:0] release_rate,
`ifdef ADSR_VELOCITY_EN
   input  logic [D_WIDTH-1:0] velocity,
`endif
   output logic [D_WIDTH-1:0] env_out,
   output logic [2:0]         state_out,
   output logic               active
);

   typedef enum logic [2:0] {
      c_ST_IDLE    = 3'd0,
      c_ST_ATTACK  = 3'd1,
      c_ST_DECAY   = 3'd2,
      c_ST_SUSTAIN = 3'd3,
      c_ST_RELEASE = 3'd4
   } state_t;

   localparam logic [R_WIDTH-1:0] c_ACC_ONES = {R_WIDTH{1'b1}};
   localparam logic [R_WIDTH-1:0] c_ACC_ZERO = {R_WIDTH{1'b0}};

   state_t               r_state;
   logic [R_WIDTH-1:0]   r_acc;
   logic                 r_gate_d;
   logic                 r_trig;
   logic [D_WIDTH-1:0]   r_env;
   logic [2:0]           r_state_o;
   logic                 r_active;

`ifdef ADSR_VELOCITY_EN
   logic [2*D_WIDTH-1:0] r_prod;
   logic [2:0]           r_state_p;
   logic                 r_active_p;
`endif

   logic                 w_rise;
   logic [R_WIDTH-1:0]   w_sus;
   logic [R_WIDTH:0]     w_att_sum;
   logic [R_WIDTH:0]     w_dec_diff;
   logic                 w_att_sat;
   logic                 w_dec_done;
   logic                 w_rel_done;
   logic [D_WIDTH-1:0]   w_level;

   assign w_rise     = gate & ~r_gate_d;
   assign w_sus      = {sustain_level, {(R_WIDTH-D_WIDTH){1'b0}}};
   assign w_level    = r_acc[R_WIDTH-1 -: D_WIDTH];

   // One extra bit on each side catches carry-out / borrow for saturation.
   assign w_att_sum  = {1'b0, r_acc} + {1'b0, attack_rate};
   assign w_dec_diff = {1'b0, r_acc} - {1'b0, decay_rate};

   assign w_att_sat  = (attack_rate == c_ACC_ZERO) || w_att_sum[R_WIDTH]
                       || (w_att_sum[R_WIDTH-1:0] == c_ACC_ONES);
   assign w_dec_done = (decay_rate == c_ACC_ZERO) || w_dec_diff[R_WIDTH]
                       || (w_dec_diff[R_WIDTH-1:0] <= w_sus);
   assign w_rel_done = (release_rate == c_ACC_ZERO) || (r_acc <= release_rate);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state    <= c_ST_IDLE;
         r_acc      <= c_ACC_ZERO;
         r_gate_d   <= 1'b0;
         r_trig     <= 1'b0;
         r_env      <= '0;
         r_state_o  <= 3'd0;
         r_active   <= 1'b0;
`ifdef ADSR_VELOCITY_EN
         r_prod     <= '0;
         r_state_p  <= 3'd0;
         r_active_p <= 1'b0;
`endif
      end else begin
         r_gate_d <= gate;
         // A new edge on a tick cycle survives that tick's clear.
         r_trig   <= w_rise | (r_trig & ~En);

         if (En) begin
            if (r_trig) begin
               r_state <= c_ST_ATTACK;
            end else if (!gate && (r_state == c_ST_ATTACK || r_state == c_ST_DECAY
                                   || r_state == c_ST_SUSTAIN)) begin
               r_state <= c_ST_RELEASE;
            end else begin
               case (r_state)
                  c_ST_ATTACK: begin
                     if (w_att_sat) begin
                        r_acc   <= c_ACC_ONES;
                        r_state <= c_ST_DECAY;
                     end else begin
                        r_acc   <= w_att_sum[R_WIDTH-1:0];
                     end
                  end
                  c_ST_DECAY: begin
                     if (w_dec_done) begin
                        r_acc   <= w_sus;
                        r_state <= c_ST_SUSTAIN;
                     end else begin
                        r_acc   <= w_dec_diff[R_WIDTH-1:0];
                     end
                  end
                  c_ST_SUSTAIN: begin
                     r_acc <= w_sus;
                  end
                  c_ST_RELEASE: begin
                     if (w_rel_done) begin
                        r_acc   <= c_ACC_ZERO;
                        r_state <= c_ST_IDLE;
                     end else begin
                        r_acc   <= r_acc - release_rate;
                     end
                  end
                  default: begin
                     r_acc   <= c_ACC_ZERO;
                     r_state <= c_ST_IDLE;
                  end
               endcase
            end
         end

`ifdef ADSR_VELOCITY_EN
         r_prod     <= {{D_WIDTH{1'b0}}, w_level} * {{D_WIDTH{1'b0}}, velocity};
         r_state_p  <= r_state;
         r_active_p <= (r_state != c_ST_IDLE);
         r_env      <= r_prod[2*D_WIDTH-1 -: D_WIDTH];
         r_state_o  <= r_state_p;
         r_active   <= r_active_p;
`else
         r_env      <= w_level;
         r_state_o  <= r_state;
         r_active   <= (r_state != c_ST_IDLE);
`endif
      end
   end

   assign env_out   = r_env;
   assign state_out = r_state_o;
   assign active    = r_active;

endmodule

`default_nettype wire
